draw_bg_ctrl: RTL and testbench

Frame-synchronous configuration controller for the background circle-wave renderer. Accepts parameter writes from the game logic over a valid/ready port into shadow registers, commits them atomically at the start of vertical blank, and drives the live circle-centre, wave-shift and base-colour values consumed by the background drawer. Optionally animates the circle centre as a bouncing point, stepping once per frame.

---
 rtl/vga_pkg.sv | 35 +++
 rtl/bg_bounce_axis.sv | 54 +++++
 rtl/draw_bg_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_draw_bg_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg -- constants shared by the VGA drawing blocks.
//
// Contents:
//   HOR_PIXELS / VER_PIXELS : visible frame size.
//   bg_cfg_addr_e           : register map of the background controller's config port.
//   BG_RGB_RST / BG_SHIFT_RST : reset values for base colour and wave shift.
//   bg_clamp_coord()        : clamps an 11-bit signed coordinate to [0, limit-1].
package vga_pkg;

    localparam int HOR_PIXELS = 800;
    localparam int VER_PIXELS = 600;

    typedef enum logic [1:0] {
        BG_X     = 2'd0,
        BG_Y     = 2'd1,
        BG_RGB   = 2'd2,
        BG_SHIFT = 2'd3
    } bg_cfg_addr_e;

    localparam logic [11:0] BG_RGB_RST   = 12'h79A;
    localparam logic [1:0]  BG_SHIFT_RST = 2'd2;

    // raw is interpreted as signed: negative values clamp to 0.
    function automatic logic signed [10:0] bg_clamp_coord(input logic [10:0] raw,
                                                          input int          limit);
        if (raw[10]) begin
            return '0;
        end
        if (int'(raw) > limit - 1) begin
            return 11'(limit - 1);
        end
        return $signed(raw);
    endfunction

endpackage

// File: rtl/bg_bounce_axis.sv
// bg_bounce_axis -- one axis of the bouncing-centre animation.
//
// Combinational. Advances pos by STEP in the current direction; if the result
// leaves [0, limit-1] the position clamps to the crossed bound and the direction
// flips. With en low the position and direction pass through unchanged.
//
// Ports:
//   pos      in  11 signed : current position.
//   dir      in  1         : 1 = increasing, 0 = decreasing.
//   limit    in  11        : axis size in pixels (bound is limit-1).
//   en       in  1         : apply the step.
//   pos_next out 11 signed : stepped position.
//   dir_next out 1         : direction after the step.
//
// Only built with DRAW_BG_BOUNCE_EN defined.
`ifdef DRAW_BG_BOUNCE_EN
module bg_bounce_axis #(
    parameter int STEP = 2
) (
    input  logic signed [10:0] pos,
    input  logic               dir,
    input  logic [10:0]        limit,
    input  logic               en,
    output logic signed [10:0] pos_next,
    output logic               dir_next
);

    localparam logic signed [12:0] STEP_W = 13'(STEP);

    logic signed [12:0] pos_w;
    logic signed [12:0] lim_w;
    logic signed [12:0] sum;

    always_comb begin
        pos_w    = $signed({{2{pos[10]}}, pos});
        lim_w    = $signed({2'b00, limit});
        sum      = dir ? (pos_w + STEP_W) : (pos_w - STEP_W);
        pos_next = pos;
        dir_next = dir;
        if (en) begin
            if (sum < 13'sd0) begin
                pos_next = '0;
                dir_next = 1'b1;
            end else if (sum > lim_w - 13'sd1) begin
                pos_next = 11'(lim_w - 13'sd1);
                dir_next = 1'b0;
            end else begin
                pos_next = sum[10:0];
            end
        end
    end

endmodule
`endif

// File: rtl/draw_bg_ctrl.sv
// draw_bg_ctrl -- frame-synchronous configuration for the background renderer.
//
// Host writes land in shadow registers and are committed to the live outputs
// atomically on the rising edge of vblnk, so the live values never change during
// active video. Optional bouncing-centre animation: define DRAW_BG_BOUNCE_EN.
//
// Ports:
//   clk, rst     : pixel clock, synchronous active-high reset.
//   vblnk        : vertical blank from VGA timing.
//   cfg_valid/cfg_ready/cfg_addr/cfg_data : write port (addr 0 X, 1 Y, 2 RGB, 3 shift).
//   x_c, y_c     : live circle centre (signed).
//   base_rgb     : live base colour.
//   wave_shift   : live wave shift.
//   frame_start  : one-cycle pulse in the commit cycle.
module draw_bg_ctrl
    import vga_pkg::*;
#(
    parameter int          X_INIT   = 220,
    parameter int          Y_INIT   = 240,
    parameter logic [11:0] RGB_INIT = BG_RGB_RST,
    parameter int          STEP     = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               vblnk,
    input  logic               cfg_valid,
    input  logic [1:0]         cfg_addr,
    input  logic [11:0]        cfg_data,
    output logic               cfg_ready,
    output logic signed [10:0] x_c,
    output logic signed [10:0] y_c,
    output logic [11:0]        base_rgb,
    output logic [1:0]         wave_shift,
    output logic               frame_start
);

    if (STEP < 1 || STEP > 15) begin : g_step_range
        $error("draw_bg_ctrl: STEP must be in 1..15");
    end

    localparam logic signed [10:0] X_RST = 11'(X_INIT);
    localparam logic signed [10:0] Y_RST = 11'(Y_INIT);

    typedef enum logic [1:0] {
        ST_ACTIVE,
`ifdef DRAW_BG_BOUNCE_EN
        ST_BOUNCE,
`endif
        ST_COMMIT
    } state_e;

    state_e state_q, state_d;

    logic               vblnk_q, vblnk_d;
    logic               vblnk_rise;
    logic               wr_en;
    logic               cfg_ready_q, cfg_ready_d;
    logic               frame_start_q, frame_start_d;
    logic signed [10:0] x_c_q, x_c_d;
    logic signed [10:0] y_c_q, y_c_d;
    logic signed [10:0] x_sh_q, x_sh_d;
    logic signed [10:0] y_sh_q, y_sh_d;
    logic [11:0]        rgb_q, rgb_d;
    logic [11:0]        rgb_sh_q, rgb_sh_d;
    logic [1:0]         shift_q, shift_d;
    logic [1:0]         shift_sh_q, shift_sh_d;
    logic [3:0]         dirty_q, dirty_d;

`ifdef DRAW_BG_BOUNCE_EN
    logic               dir_x_q, dir_x_d;
    logic               dir_y_q, dir_y_d;
    // Axis written by the host in the current frame: skip its bounce step.
    logic               hold_x_q, hold_x_d;
    logic               hold_y_q, hold_y_d;
    logic signed [10:0] bx_next, by_next;
    logic               bdx_next, bdy_next;

    bg_bounce_axis #(.STEP(STEP)) u_bounce_x (
        .pos      (x_c_q),
        .dir      (dir_x_q),
        .limit    (11'(HOR_PIXELS)),
        .en       (~hold_x_q),
        .pos_next (bx_next),
        .dir_next (bdx_next)
    );

    bg_bounce_axis #(.STEP(STEP)) u_bounce_y (
        .pos      (y_c_q),
        .dir      (dir_y_q),
        .limit    (11'(VER_PIXELS)),
        .en       (~hold_y_q),
        .pos_next (by_next),
        .dir_next (bdy_next)
    );
`endif

    assign vblnk_rise  = vblnk & ~vblnk_q;
    assign wr_en       = cfg_valid & cfg_ready_q;

    assign cfg_ready   = cfg_ready_q;
    assign frame_start = frame_start_q;
    assign x_c         = x_c_q;
    assign y_c         = y_c_q;
    assign base_rgb    = rgb_q;
    assign wave_shift  = shift_q;

    always_comb begin
        state_d    = state_q;
        vblnk_d    = vblnk;
        x_c_d      = x_c_q;
        y_c_d      = y_c_q;
        rgb_d      = rgb_q;
        shift_d    = shift_q;
        x_sh_d     = x_sh_q;
        y_sh_d     = y_sh_q;
        rgb_sh_d   = rgb_sh_q;
        shift_sh_d = shift_sh_q;
        dirty_d    = dirty_q;
`ifdef DRAW_BG_BOUNCE_EN
        dir_x_d    = dir_x_q;
        dir_y_d    = dir_y_q;
        hold_x_d   = hold_x_q;
        hold_y_d   = hold_y_q;
`endif

        unique case (state_q)
            ST_ACTIVE: begin
                if (vblnk_rise) begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                if (dirty_q[BG_X])     x_c_d   = x_sh_q;
                if (dirty_q[BG_Y])     y_c_d   = y_sh_q;
                if (dirty_q[BG_RGB])   rgb_d   = rgb_sh_q;
                if (dirty_q[BG_SHIFT]) shift_d = shift_sh_q;
                dirty_d = '0;
`ifdef DRAW_BG_BOUNCE_EN
                hold_x_d = dirty_q[BG_X];
                hold_y_d = dirty_q[BG_Y];
                state_d  = ST_BOUNCE;
`else
                state_d  = ST_ACTIVE;
`endif
            end
`ifdef DRAW_BG_BOUNCE_EN
            ST_BOUNCE: begin
                x_c_d   = bx_next;
                y_c_d   = by_next;
                dir_x_d = bdx_next;
                dir_y_d = bdy_next;
                state_d = ST_ACTIVE;
            end
`endif
            default: state_d = ST_ACTIVE;
        endcase

        // Writes are only accepted in ACTIVE, so a write in the edge cycle
        // reaches the shadow before the COMMIT cycle reads it.
        if (wr_en) begin
            unique case (bg_cfg_addr_e'(cfg_addr))
                BG_X:     x_sh_d     = bg_clamp_coord(cfg_data[10:0], HOR_PIXELS);
                BG_Y:     y_sh_d     = bg_clamp_coord(cfg_data[10:0], VER_PIXELS);
                BG_RGB:   rgb_sh_d   = cfg_data;
                BG_SHIFT: shift_sh_d = cfg_data[1:0];
                default:  ;
            endcase
            dirty_d[cfg_addr] = 1'b1;
        end

        cfg_ready_d   = (state_d == ST_ACTIVE);
        frame_start_d = (state_d == ST_COMMIT);
    end

    always_ff @(posedge clk) begin
        // Edge detector keeps tracking through reset so a reset released
        // inside vblank does not fire a spurious frame.
        vblnk_q <= vblnk_d;
        if (rst) begin
            state_q       <= ST_ACTIVE;
            cfg_ready_q   <= 1'b0;
            frame_start_q <= 1'b0;
            x_c_q         <= X_RST;
            y_c_q         <= Y_RST;
            rgb_q         <= RGB_INIT;
            shift_q       <= BG_SHIFT_RST;
            x_sh_q        <= X_RST;
            y_sh_q        <= Y_RST;
            rgb_sh_q      <= RGB_INIT;
            shift_sh_q    <= BG_SHIFT_RST;
            dirty_q       <= '0;
`ifdef DRAW_BG_BOUNCE_EN
            dir_x_q       <= 1'b1;
            dir_y_q       <= 1'b1;
            hold_x_q      <= 1'b0;
            hold_y_q      <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            cfg_ready_q   <= cfg_ready_d;
            frame_start_q <= frame_start_d;
            x_c_q         <= x_c_d;
            y_c_q         <= y_c_d;
            rgb_q         <= rgb_d;
            shift_q       <= shift_d;
            x_sh_q        <= x_sh_d;
            y_sh_q        <= y_sh_d;
            rgb_sh_q      <= rgb_sh_d;
            shift_sh_q    <= shift_sh_d;
            dirty_q       <= dirty_d;
`ifdef DRAW_BG_BOUNCE_EN
            dir_x_q       <= dir_x_d;
            dir_y_q       <= dir_y_d;
            hold_x_q      <= hold_x_d;
            hold_y_q      <= hold_y_d;
`endif
        end
    end

endmodule

// File: tb/tb_draw_bg_ctrl.sv
`timescale 1ns/1ps
module tb_draw_bg_ctrl;
    import vga_pkg::*;

`ifdef DRAW_BG_BOUNCE_EN
    localparam bit BOUNCE = 1'b1;
`else
    localparam bit BOUNCE = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               vblnk = 1'b0;
    logic               cfg_valid = 1'b0;
    logic [1:0]         cfg_addr = '0;
    logic [11:0]        cfg_data = '0;
    logic               cfg_ready;
    logic signed [10:0] x_c;
    logic signed [10:0] y_c;
    logic [11:0]        base_rgb;
    logic [1:0]         wave_shift;
    logic               frame_start;

    draw_bg_ctrl #(
        .X_INIT   (220),
        .Y_INIT   (240),
        .RGB_INIT (12'h79A),
        .STEP     (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .vblnk       (vblnk),
        .cfg_valid   (cfg_valid),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .cfg_ready   (cfg_ready),
        .x_c         (x_c),
        .y_c         (y_c),
        .base_rgb    (base_rgb),
        .wave_shift  (wave_shift),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    // Expected live values two cycles after the edge (bx/by: three cycles, bounce build).
    typedef struct {
        int x;
        int y;
        int rgb;
        int sh;
        int bx;
        int by;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_frames = 0;

    task automatic chk(input string name, input int act, input int want);
        n_checks++;
        if (act == want) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, want, want);
    endtask

    task automatic push_exp(input int x, input int y, input int rgb, input int sh,
                            input int bx, input int by);
        exp_t e;
        e = '{x, y, rgb, sh, bx, by};
        exp_q.push_back(e);
    endtask

    // Called just after a posedge; returns just after the accepting posedge.
    task automatic cfg_write(input bg_cfg_addr_e a, input logic [11:0] d);
        int n;
        n = 0;
        cfg_valid = 1'b1;
        cfg_addr  = a;
        cfg_data  = d;
        @(negedge clk);
        while (cfg_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (cfg_ready !== 1'b1) begin
            n_checks++;
            $display("FAIL write_accept: cfg_ready=%b after 50 cycles, required 1", cfg_ready);
        end
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
    endtask

    task automatic vblank_frame(input int x, input int y, input int rgb, input int sh,
                                input int bx, input int by);
        push_exp(x, y, rgb, sh, bx, by);
        vblnk = 1'b1;
        repeat (6) @(posedge clk);
        #1 vblnk = 1'b0;
        repeat (6) @(posedge clk);
        #1;
    endtask

    // Monitor: every frame_start pulse consumes one expected entry.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (frame_start === 1'b1) begin
                n_frames++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_frame: frame_start pulse %0d with nothing expected", n_frames);
                end else begin
                    e = exp_q.pop_front();
                    @(negedge clk);
                    chk("frame_start_width", int'(frame_start), 0);
                    chk("x_c_commit", int'(x_c), e.x);
                    chk("y_c_commit", int'(y_c), e.y);
                    chk("base_rgb_commit", int'(base_rgb), e.rgb);
                    chk("wave_shift_commit", int'(wave_shift), e.sh);
`ifdef DRAW_BG_BOUNCE_EN
                    @(negedge clk);
                    chk("x_c_bounce", int'(x_c), e.bx);
                    chk("y_c_bounce", int'(y_c), e.by);
`endif
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_x_c", int'(x_c), 220);
        chk("reset_y_c", int'(y_c), 240);
        chk("reset_rgb", int'(base_rgb), 12'h79A);
        chk("reset_shift", int'(wave_shift), 2);
        chk("reset_ready", int'(cfg_ready), 0);
        chk("reset_frame_start", int'(frame_start), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("ready_first_cycle", int'(cfg_ready), 0);
        @(negedge clk);
        chk("ready_after_reset", int'(cfg_ready), 1);
        @(posedge clk);
        #1;

        // F1: mid-frame X write is invisible until the commit
        cfg_write(BG_X, 12'd400);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("x_before_commit", int'(x_c), 220);
        @(posedge clk);
        #1;
        vblank_frame(400, 240, 12'h79A, 2, 400, 242);

        // F2: clamping of negative X and oversized Y
        cfg_write(BG_X, 12'h7FF);
        cfg_write(BG_Y, 12'd1000);
        vblank_frame(0, VER_PIXELS - 1, 12'h79A, 2, 0, VER_PIXELS - 1);

        // F3: last write wins, write coincident with the edge, write held over COMMIT
        cfg_write(BG_RGB, 12'h111);
        cfg_write(BG_RGB, 12'h222);
        push_exp(0, 599, 12'h222, 1, 2, 599);
        vblnk     = 1'b1;
        cfg_valid = 1'b1;
        cfg_addr  = BG_SHIFT;
        cfg_data  = 12'h001;
        @(negedge clk);
        chk("ready_at_edge", int'(cfg_ready), 1);
        @(posedge clk);
        #1;
        cfg_addr = BG_X;
        cfg_data = 12'd5;
        @(negedge clk);
        chk("ready_in_commit", int'(cfg_ready), 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("ready_after_commit", int'(cfg_ready), BOUNCE ? 0 : 1);
        n = 0;
        while (cfg_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (cfg_ready !== 1'b1) begin
            n_checks++;
            $display("FAIL held_write_accept: cfg_ready=%b, required 1", cfg_ready);
        end
        @(posedge clk);
        #1 cfg_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 vblnk = 1'b0;
        repeat (6) @(posedge clk);
        #1;

        // F4: held write committed in the following frame
        vblank_frame(5, 599, 12'h222, 1, 5, 597);

        // F5: reset during COMMIT discards pending shadows
        cfg_write(BG_Y, 12'd100);
        cfg_write(BG_RGB, 12'hABC);
        push_exp(220, 240, 12'h79A, 2, 220, 240);
        vblnk = 1'b1;
        @(posedge clk);
        #1;
        rst   = 1'b1;
        vblnk = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("ready_reset_exit", int'(cfg_ready), 0);
        @(negedge clk);
        chk("ready_reset_exit_next", int'(cfg_ready), 1);
        @(posedge clk);
        #1;
        repeat (6) @(posedge clk);
        #1;

        // F6: nothing pending, values stay at reset
        vblank_frame(220, 240, 12'h79A, 2, 222, 242);

        // FA..FC: X near the right edge
        cfg_write(BG_X, 12'd798);
        vblank_frame(798, BOUNCE ? 242 : 240, 12'h79A, 2, 798, 244);
        vblank_frame(798, BOUNCE ? 244 : 240, 12'h79A, 2, HOR_PIXELS - 1, 246);
        vblank_frame(BOUNCE ? HOR_PIXELS - 1 : 798, BOUNCE ? 246 : 240, 12'h79A, 2,
                     HOR_PIXELS - 3, 248);

        repeat (5) @(posedge clk);
        chk("frame_count", n_frames, 9);
        chk("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
